// File: rtl/mem_line_server_pkg.sv
// Shared definitions for the RAM-side line transfer responder.
// State encodings and default line geometry.
package mem_line_server_pkg;

    localparam int WORDS_DEF = 8;
    localparam int IDX_W_DEF = 3;
    localparam int RD_LAT_DEF = 2;

    typedef enum logic [1:0] {
        MS_IDLE     = 2'd0,
        MS_RD_ISSUE = 2'd1,
        MS_RD_DRAIN = 2'd2,
        MS_WR       = 2'd3
    } ms_state_e;

endpackage

// File: rtl/mem_line_server_rd_lat_pipe.sv
// Tracks in-flight RAM reads: a shift register of {valid, word index}
// whose head lines up with mem_rdata.
module mem_line_server_rd_lat_pipe #(
    parameter int RD_LAT = 2,
    parameter int IDX_W  = 3
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             push_i,
    input  logic [IDX_W-1:0] push_idx_i,
    output logic             head_valid_o,
    output logic [IDX_W-1:0] head_idx_o
);

    logic [RD_LAT-1:0] vld_q;
    logic [IDX_W-1:0]  idx_q [RD_LAT];

    always_ff @(posedge clk) begin
        if (!resetn) begin
            vld_q <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                idx_q[i] <= '0;
            end
        end else begin
            vld_q[0] <= push_i;
            idx_q[0] <= push_idx_i;
            for (int i = 1; i < RD_LAT; i++) begin
                vld_q[i] <= vld_q[i-1];
                idx_q[i] <= idx_q[i-1];
            end
        end
    end

    assign head_valid_o = vld_q[RD_LAT-1];
    assign head_idx_o   = idx_q[RD_LAT-1];

endmodule

// File: rtl/mem_line_server.sv
// Serves one cache line per request: WORDS-beat fill bursts from RAM
// or writeback bursts pulled from the cache by word index.
module mem_line_server
    import mem_line_server_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int WORDS  = WORDS_DEF,
    parameter int IDX_W  = IDX_W_DEF,
    parameter int RD_LAT = RD_LAT_DEF
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    output logic [IDX_W-1:0]  wb_word_sel,
    input  logic [31:0]       wb_data,
    output logic              fill_valid,
    output logic [IDX_W-1:0]  fill_word_sel,
    output logic [31:0]       fill_data,
    output logic              done,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    localparam logic [IDX_W-1:0] LAST = IDX_W'(WORDS - 1);
    localparam int TAG_W = ADDR_W - IDX_W - 2;

    ms_state_e         state_q, state_d;
    logic [IDX_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W-1:0] beat_addr;
    logic              push;
    logic              head_vld;
    logic [IDX_W-1:0]  head_idx;
    logic              fill_last;
    logic              unused_addr_lsb;

    assign unused_addr_lsb = ^req_addr[IDX_W+1:0];

    // Index is OR-inserted below the tag; base has those bits clear.
    assign beat_addr = base_q | {{TAG_W{1'b0}}, cnt_q, 2'b00};

    mem_line_server_rd_lat_pipe #(
        .RD_LAT (RD_LAT),
        .IDX_W  (IDX_W)
    ) u_pipe (
        .clk          (clk),
        .resetn       (resetn),
        .push_i       (push),
        .push_idx_i   (cnt_q),
        .head_valid_o (head_vld),
        .head_idx_o   (head_idx)
    );

    assign fill_last     = head_vld && (head_idx == LAST);
    assign fill_valid    = head_vld;
    assign fill_word_sel = head_vld ? head_idx : '0;
    assign fill_data     = head_vld ? mem_rdata : 32'd0;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= MS_IDLE;
            cnt_q   <= '0;
            base_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            base_q  <= base_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        base_d      = base_q;
        req_ready   = 1'b0;
        mem_en      = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = 32'd0;
        wb_word_sel = '0;
        push        = 1'b0;
        done        = fill_last;
        unique case (state_q)
            MS_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    base_d  = {req_addr[ADDR_W-1:IDX_W+2],
                               {(IDX_W+2){1'b0}}};
                    cnt_d   = '0;
                    state_d = req_write ? MS_WR : MS_RD_ISSUE;
                end
            end
            MS_RD_ISSUE: begin
                mem_en   = 1'b1;
                mem_addr = beat_addr;
                push     = 1'b1;
                if (cnt_q == LAST) begin
                    state_d = MS_RD_DRAIN;
                end else begin
                    cnt_d = cnt_q + IDX_W'(1);
                end
            end
            MS_RD_DRAIN: begin
                // Last word leaves the pipe this cycle; nothing else in flight.
                if (fill_last) begin
                    state_d = MS_IDLE;
                end
            end
            MS_WR: begin
                mem_en      = 1'b1;
                mem_we      = 1'b1;
                wb_word_sel = cnt_q;
                mem_addr    = beat_addr;
                mem_wdata   = wb_data;
                if (cnt_q == LAST) begin
                    done    = 1'b1;
                    state_d = MS_IDLE;
                end else begin
                    cnt_d = cnt_q + IDX_W'(1);
                end
            end
            default: begin
                state_d = MS_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_line_server.sv
// Scoreboard bench for mem_line_server: reference RAM/cache model,
// expected beats queued at issue time and checked by a cycle monitor.
module tb_mem_line_server;

    localparam int ADDR_W = 32;
    localparam int WORDS  = 8;
    localparam int IDX_W  = 3;
    localparam int RD_LAT = 2;
    localparam int MEM_N  = 1024;

    logic              clk = 1'b0;
    logic              resetn = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic              req_write = 1'b0;
    logic [ADDR_W-1:0] req_addr = '0;
    logic [IDX_W-1:0]  wb_word_sel;
    logic [31:0]       wb_data;
    logic              fill_valid;
    logic [IDX_W-1:0]  fill_word_sel;
    logic [31:0]       fill_data;
    logic              done;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    always #5 clk = ~clk;

    mem_line_server #(
        .ADDR_W (ADDR_W),
        .WORDS  (WORDS),
        .IDX_W  (IDX_W),
        .RD_LAT (RD_LAT)
    ) dut (
        .clk           (clk),
        .resetn        (resetn),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_write     (req_write),
        .req_addr      (req_addr),
        .wb_word_sel   (wb_word_sel),
        .wb_data       (wb_data),
        .fill_valid    (fill_valid),
        .fill_word_sel (fill_word_sel),
        .fill_data     (fill_data),
        .done          (done),
        .mem_en        (mem_en),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_rdata     (mem_rdata)
    );

    typedef struct {
        int          burst;
        int          off;
        logic [31:0] addr;
        logic [31:0] data;
        int          idx;
        bit          last;
    } exp_t;

    logic [31:0] ram     [MEM_N];
    logic [31:0] ref_mem [MEM_N];
    logic [31:0] line_buf [WORDS];
    logic [31:0] rd_dly  [RD_LAT];

    exp_t q_rd[$];
    exp_t q_fill[$];
    exp_t q_wr[$];
    int   acc_cyc [256];
    int   dur [256];
    int   n_req = 0;
    int   n_acc = 0;
    int   busy_end = 0;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    bit   use_b0 = 1'b0;

    function automatic int widx(input logic [ADDR_W-1:0] a);
        return int'(a[11:2]);
    endfunction

    // Environment: word RAM with RD_LAT read latency and a cache
    // that answers wb_word_sel combinationally.
    assign mem_rdata = rd_dly[RD_LAT-1];
    assign wb_data   = line_buf[wb_word_sel];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_en && mem_we) ram[widx(mem_addr)] <= mem_wdata;
        rd_dly[0] <= (mem_en && !mem_we) ? ram[widx(mem_addr)] : 32'hDEAD_BEEF;
        for (int k = 1; k < RD_LAT; k++) rd_dly[k] <= rd_dly[k-1];
    end

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    function automatic bit is_due(input exp_t h);
        return h.burst < n_acc && acc_cyc[h.burst] + h.off <= cyc;
    endfunction

    always @(negedge clk) begin : mon
        exp_t e;
        bit   exp_done;
        if (!resetn) begin
            q_rd.delete();
            q_fill.delete();
            q_wr.delete();
            busy_end = cyc;
        end else begin
            exp_done = 1'b0;
            chk("req_ready", req_ready, cyc > busy_end);
            if (req_valid && req_ready) begin
                acc_cyc[n_acc] = cyc;
                busy_end = cyc + dur[n_acc];
                n_acc++;
            end
            if (q_rd.size() > 0 && is_due(q_rd[0])) begin
                e = q_rd.pop_front();
                chk("rd_en_we", {mem_en, mem_we}, 2'b10);
                chk("rd_addr", mem_addr, e.addr);
            end else if (q_wr.size() > 0 && is_due(q_wr[0])) begin
                e = q_wr.pop_front();
                chk("wr_en_we", {mem_en, mem_we}, 2'b11);
                chk("wr_addr", mem_addr, e.addr);
                chk("wr_data", mem_wdata, e.data);
                chk("wb_word_sel", wb_word_sel, e.idx);
                exp_done |= e.last;
            end else begin
                chk("mem_en_idle", mem_en, 0);
                chk("wb_sel_idle", wb_word_sel, 0);
            end
            if (q_fill.size() > 0 && is_due(q_fill[0])) begin
                e = q_fill.pop_front();
                chk("fill_valid", fill_valid, 1);
                chk("fill_word_sel", fill_word_sel, e.idx);
                chk("fill_data", fill_data, e.data);
                exp_done |= e.last;
            end else begin
                chk("fill_valid_idle", fill_valid, 0);
            end
            chk("done", done, exp_done);
        end
    end

    task automatic send(input bit wr, input logic [ADDR_W-1:0] a,
                        input bit wait_idle, input bit drop);
        logic [ADDR_W-1:0] base;
        int id;
        int guard;
        bit ok;
        if (wait_idle) begin
            guard = 0;
            do begin
                @(negedge clk);
                guard++;
            end while (!req_ready && guard < 100);
            @(posedge clk);
            #1;
        end
        base = a & ~ADDR_W'(WORDS * 4 - 1);
        id = n_req;
        n_req++;
        dur[id] = wr ? WORDS : WORDS + RD_LAT;
        for (int i = 0; i < WORDS; i++) begin
            if (wr) begin
                line_buf[i] = use_b0 ? 32'hB0 + i : $urandom;
                q_wr.push_back('{id, 1 + i, base | ADDR_W'(i * 4),
                                 line_buf[i], i, i == WORDS - 1});
                ref_mem[widx(base) + i] = line_buf[i];
            end else begin
                q_rd.push_back('{id, 1 + i, base | ADDR_W'(i * 4),
                                 32'd0, i, 1'b0});
                q_fill.push_back('{id, 1 + RD_LAT + i, 32'd0,
                                   ref_mem[widx(base) + i], i,
                                   i == WORDS - 1});
            end
        end
        req_write = wr;
        req_addr  = a;
        req_valid = 1'b1;
        guard = 0;
        do begin
            @(negedge clk);
            ok = req_ready;
            @(posedge clk);
            #1;
            guard++;
        end while (!ok && guard < 200);
        if (!ok) chk("accept_timeout", 0, 1);
        if (drop) req_valid = 1'b0;
    endtask

    initial begin : main
        int mism;
        int guard;
        for (int i = 0; i < MEM_N; i++) ref_mem[i] = $urandom;
        for (int w = 0; w < WORDS; w++) ref_mem[widx(32'h1220) + w] = 32'hA000_0000 + w;
        for (int i = 0; i < MEM_N; i++) ram[i] = ref_mem[i];
        for (int w = 0; w < WORDS; w++) line_buf[w] = 32'd0;
        for (int k = 0; k < RD_LAT; k++) rd_dly[k] = 32'd0;

        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;
        repeat (10) @(posedge clk);
        #1;

        send(1'b0, 32'h0000_1234, 1'b1, 1'b1);
        use_b0 = 1'b1;
        send(1'b1, 32'h0000_0040, 1'b1, 1'b1);
        use_b0 = 1'b0;

        // Requests pulsed while a fill is running must be ignored.
        send(1'b0, $urandom, 1'b1, 1'b1);
        for (int i = 0; i < 6; i++) begin
            req_write = 1'b1;
            req_addr  = $urandom;
            req_valid = i[0];
            @(posedge clk);
            #1;
        end
        req_valid = 1'b0;

        // Reset lands in the middle of a fill.
        send(1'b0, $urandom, 1'b1, 1'b1);
        repeat (4) @(posedge clk);
        #1 resetn = 1'b0;
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
        send(1'b0, 32'h0000_1234, 1'b1, 1'b1);

        // Fill then writeback with req_valid held high.
        send(1'b0, $urandom, 1'b1, 1'b0);
        send(1'b1, $urandom, 1'b0, 1'b1);
        chk("b2b_gap", acc_cyc[n_req-1] - acc_cyc[n_req-2],
            WORDS + RD_LAT + 1);

        for (int n = 0; n < 30; n++) begin
            if (($urandom % 4) == 0) begin
                send(1'b0, $urandom, 1'b1, 1'b0);
                send(1'b1, $urandom, 1'b0, 1'b1);
            end else begin
                send(1'($urandom % 2), $urandom, 1'b1, 1'b1);
            end
        end

        guard = 0;
        while ((q_rd.size() + q_fill.size() + q_wr.size()) != 0 && guard < 200) begin
            @(posedge clk);
            guard++;
        end
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("queues_drained", q_rd.size() + q_fill.size() + q_wr.size(), 0);
        chk("accept_count", n_acc, n_req);
        mism = 0;
        for (int i = 0; i < MEM_N; i++) if (ram[i] !== ref_mem[i]) mism++;
        chk("ram_contents", mism, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_line_server.md
Name: mem_line_server

Overview:
RAM-side responder for the cache manage unit's line transfers. It accepts one line request, either a fill for the I-cache/D-cache or a D-cache writeback. It then performs a WORDS-beat burst against a single-port word RAM with fixed read latency. Fill words are returned to the cache tagged with their word index. Writeback words are pulled from the cache by word index.

Parameters:
ADDR_W, 32, byte address width
WORDS, 8, words per cache line; power of two
IDX_W, 3, log2(WORDS); width of word-select fields
RD_LAT, 2, cycles from mem_en (read) to mem_rdata valid; legal range 1..4

Ports:
clk  in  1  system clock
resetn  in  1  synchronous active-low reset
req_valid  in  1  line request present
req_ready  out  1  high only in IDLE; request accepted when req_valid&&req_ready
req_write  in  1  1 = writeback, 0 = fill
req_addr  in  ADDR_W  line address; low IDX_W+2 bits ignored
wb_word_sel  out  IDX_W  word index requested from cache during writeback
wb_data  in  32  cache word for wb_word_sel, combinationally valid in the same cycle
fill_valid  out  1  fill word present this cycle
fill_word_sel  out  IDX_W  index of the fill word
fill_data  out  32  fill word
done  out  1  one-cycle pulse, concurrent with the final beat
mem_en  out  1  RAM access enable
mem_we  out  1  RAM write enable
mem_addr  out  ADDR_W  RAM byte address (word aligned)
mem_wdata  out  32  RAM write data
mem_rdata  in  32  RAM read data, valid RD_LAT cycles after a read mem_en

Behaviour:
- Reset (resetn=0 at a clk edge): state=IDLE, counter=0, base=0, latency pipe flushed. All outputs are 0 except req_ready=1. Reset mid-burst aborts the burst: no further fill_valid, no done.
- Accept edge: latch base={req_addr[ADDR_W-1:IDX_W+2], 0} and req_write, counter=0.
- Next state: RD_ISSUE if req_write=0, else WR.
- State IDLE: mem_en=0, fill_valid=0, done=0. Requests arriving outside IDLE are ignored; req_ready=0 in every other state.
- State RD_ISSUE: mem_en=1, mem_we=0, mem_addr=base|(counter<<2).
  - Push {1, counter} into the RD_LAT-deep pipe; counter increments by 1.
  - When counter==WORDS-1, the next state is RD_DRAIN.
- State RD_DRAIN: mem_en=0. Leave when the pipe is empty after the last word emerges; next state IDLE.
- Pipe output (any state): fill_valid=pipe valid, fill_word_sel=pipe idx, fill_data=mem_rdata. This is combinational from the pipe head.
- Fill done: asserted together with fill_valid for idx WORDS-1.
- Fill timing: accept at cycle 0, issues in cycles 1..WORDS, fills in cycles 1+RD_LAT..WORDS+RD_LAT. req_ready returns in cycle WORDS+RD_LAT+1.
- State WR: mem_en=1, mem_we=1, wb_word_sel=counter, mem_addr=base|(counter<<2), mem_wdata=wb_data. counter increments each cycle.
- Write done: asserted in the cycle counter==WORDS-1; next state IDLE. Writes occupy cycles 1..WORDS.
- wb_word_sel outside WR: held at 0.
- Counter: IDX_W bits and never wraps inside a burst. Terminal value is WORDS-1; counter is reset to 0 on each accept.
- Address arithmetic: OR-insertion of the index into base, no carry into the tag bits.
- Back-to-back requests: the earliest new accept is the cycle after done+drain; no overlap of bursts.

Decomposition:
- Shared header mem_server.vh, mirroring status.vh: state encodings (MS_IDLE, MS_RD_ISSUE, MS_RD_DRAIN, MS_WR) and defaults for WORDS/IDX_W.
- Sub-module rd_lat_pipe: RD_LAT-stage shift register of {valid, idx} with synchronous flush on reset.

Test Plan:
- Reset, then idle: req_ready=1, mem_en=0, fill_valid=0, done=0 for 10 cycles.
- Fill req_addr=0x0000_1234, RAM[w]=0xA000_0000+w, RD_LAT=2:
  - mem_addr 0x1220..0x123C in cycles 1..8.
  - fill_valid cycles 3..10, fill_data 0xA0000000..0xA0000007 with matching fill_word_sel.
  - done in cycle 10 only; req_ready=1 in cycle 11.
- Writeback req_addr=0x0000_0040, cache model returns 0xB0+sel:
  - wb_word_sel 0..7 in cycles 1..8, RAM 0x40..0x5C written 0xB0..0xB7, done in cycle 8.
- Request pulses asserted during a fill: ignored, req_ready=0 throughout, RAM untouched, single done.
- resetn=0 at cycle 5 of a fill: no fill_valid after reset, no done, req_ready=1 the cycle after reset release; a new fill completes correctly.
- Fill immediately followed by a writeback (req_valid held high): second accept in cycle WORDS+RD_LAT+1; sequences do not overlap; RD_LAT=1 and RD_LAT=4 builds both pass.
